// File: rtl/fpu_seq_ctrl_if.sv
// Bundle between ID/EX, the FPU sequencer and the FPU datapath.
// slave: sequencer side; master: pipeline/datapath side.
interface fpu_seq_ctrl_if;
    logic        ex_valid;
    logic        ex_flush;
    logic [4:0]  ID_EX_alu_func;
    logic [2:0]  flt_rm;
    logic [2:0]  frm_csr;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] dp_res;
    logic [31:0] dp_opa;
    logic [31:0] dp_opb;
    logic [4:0]  dp_func;
    logic [2:0]  dp_rm;
    logic        fpu_busy;
    logic        fpu_res_valid;
    logic [31:0] fpu_res;
    logic        fpu_illegal_rm;

    modport slave (
        input  ex_valid, ex_flush, ID_EX_alu_func,
        input  flt_rm, frm_csr, opa, opb, dp_res,
        output dp_opa, dp_opb, dp_func, dp_rm,
        output fpu_busy, fpu_res_valid, fpu_res,
        output fpu_illegal_rm
    );

    modport master (
        output ex_valid, ex_flush, ID_EX_alu_func,
        output flt_rm, frm_csr, opa, opb, dp_res,
        input  dp_opa, dp_opb, dp_func, dp_rm,
        input  fpu_busy, fpu_res_valid, fpu_res,
        input  fpu_illegal_rm
    );
endinterface

// File: rtl/fpu_seq_ctrl.sv
// FPU issue/stall sequencer: latches one FP op, stalls for its
// class latency, strobes the datapath result. Ports: clk, rst, bus.
module fpu_seq_ctrl #(
    parameter int         LAT_CVT      = 1,
    parameter int         LAT_ADD      = 3,
    parameter int         LAT_MUL      = 4,
    parameter int         LAT_DIV      = 16,
    parameter int         CNT_W        = 5,
    parameter logic [4:0] ALU_FADD     = 5'h10,
    parameter logic [4:0] ALU_FSUB     = 5'h11,
    parameter logic [4:0] ALU_FMUL     = 5'h12,
    parameter logic [4:0] ALU_FDIV     = 5'h13,
    parameter logic [4:0] ALU_FCVTSW   = 5'h14,
    parameter logic [4:0] ALU_FCVTSWU  = 5'h15
) (
    input  logic           clk,
    input  logic           rst,
    fpu_seq_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] L_CVT = CNT_W'(LAT_CVT);
    localparam logic [CNT_W-1:0] L_ADD = CNT_W'(LAT_ADD);
    localparam logic [CNT_W-1:0] L_MUL = CNT_W'(LAT_MUL);
    localparam logic [CNT_W-1:0] L_DIV = CNT_W'(LAT_DIV);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] lat;
    logic             is_fp;
    logic [2:0]       rm_res;
    logic             rm_ill;
    logic             ill_q;
    logic             issue;
    logic             busy;
    logic             res_vld;
    logic [4:0]       fn;

    logic [31:0]      opa_q;
    logic [31:0]      opb_q;
    logic [4:0]       func_q;
    logic [2:0]       rm_q;

    assign fn = bus.ID_EX_alu_func;

    always_comb begin
        is_fp = 1'b0;
        lat   = L_CVT;
        unique case (1'b1)
            (fn == ALU_FCVTSW) || (fn == ALU_FCVTSWU): begin
                is_fp = 1'b1;
                lat   = L_CVT;
            end
            (fn == ALU_FADD) || (fn == ALU_FSUB): begin
                is_fp = 1'b1;
                lat   = L_ADD;
            end
            (fn == ALU_FMUL): begin
                is_fp = 1'b1;
                lat   = L_MUL;
            end
            (fn == ALU_FDIV): begin
                is_fp = 1'b1;
                lat   = L_DIV;
            end
            default: begin
                is_fp = 1'b0;
                lat   = L_CVT;
            end
        endcase
    end

    // 3'b111 selects the dynamic mode from fcsr.
    assign rm_res = (bus.flt_rm == 3'b111) ? bus.frm_csr : bus.flt_rm;
    assign rm_ill = (rm_res >= 3'd5);

    // rst gates issue so the combinational stall is low in reset.
    assign issue = rst && (state == IDLE) && bus.ex_valid
                   && is_fp && !bus.ex_flush;

    always_comb begin
        state_d = state;
        busy    = 1'b0;
        res_vld = 1'b0;
        unique case (state)
            IDLE: begin
                busy = issue;
                if (issue)
                    state_d = (lat == ONE) ? DONE : BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (bus.ex_flush)
                    state_d = IDLE;
                else if (cnt <= ONE)
                    state_d = DONE;
            end
            DONE: begin
                res_vld = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            func_q <= '0;
            rm_q   <= '0;
            ill_q  <= 1'b0;
        end else begin
            state <= state_d;
            if (issue) begin
                cnt    <= lat - ONE;
                opa_q  <= bus.opa;
                opb_q  <= bus.opb;
                func_q <= fn;
                rm_q   <= rm_res;
                ill_q  <= rm_ill;
            end else if (state == BUSY && cnt != '0) begin
                cnt <= cnt - ONE;
            end
        end
    end

    assign bus.dp_opa         = opa_q;
    assign bus.dp_opb         = opb_q;
    assign bus.dp_func        = func_q;
    assign bus.dp_rm          = rm_q;
    assign bus.fpu_busy       = busy;
    assign bus.fpu_res_valid  = res_vld;
    assign bus.fpu_res        = res_vld ? bus.dp_res : 32'h0;
    assign bus.fpu_illegal_rm = res_vld && ill_q;

endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
Issue/stall sequencer placed between the ID/EX stage and the FPU datapath.
- Accepts one FP instruction at a time from ID/EX.
- Registers its operands, function code and resolved rounding mode, and holds them stable on the datapath inputs.
- Counts a per-class latency, stalls the pipeline through `fpu_busy`, and returns the result with a one-cycle valid pulse.
- Latencies are per-class parameters, so the datapath can be moved from combinational to pipelined or iterative without touching the pipeline.

Parameters:
LAT_CVT, 1, cycles from issue to result for ALU_FCVTSW / ALU_FCVTSWU (>=1)
LAT_ADD, 3, latency for ALU_FADD / ALU_FSUB (>=1)
LAT_MUL, 4, latency for ALU_FMUL (>=1)
LAT_DIV, 16, latency for ALU_FDIV (>=1)
CNT_W, 5, latency counter width; every LAT_* must be < 2**CNT_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  ID/EX holds a valid instruction
ex_flush  in  1  squash the instruction in EX (branch/exception)
ID_EX_alu_func  in  5  ALU function code (sys_defs.vh encodings)
flt_rm  in  3  instruction rounding-mode field
frm_csr  in  3  dynamic rounding mode from the fcsr CSR
opa  in  32  operand A
opb  in  32  operand B
dp_res  in  32  FPU datapath result, combinational from dp_* inputs
dp_opa  out  32  registered operand A to datapath
dp_opb  out  32  registered operand B to datapath
dp_func  out  5  registered function code to datapath
dp_rm  out  3  resolved rounding mode to datapath
fpu_busy  out  1  pipeline stall request
fpu_res_valid  out  1  one-cycle result strobe
fpu_res  out  32  result; 0 when fpu_res_valid is low
fpu_illegal_rm  out  1  resolved rm illegal; valid only with fpu_res_valid

Behaviour:
- `is_fp`: ID_EX_alu_func is one of ALU_FCVTSW, ALU_FCVTSWU, ALU_FADD, ALU_FSUB, ALU_FMUL, ALU_FDIV. Every other code is ignored and never stalls.
- `issue` = (state==IDLE) && ex_valid && is_fp && !ex_flush.
- States are IDLE, BUSY and DONE. Async reset forces IDLE, cnt=0, all dp_* = 0 and all outputs 0, at any time including mid-operation.
- IDLE:
  - fpu_busy = issue. This is combinational, so the stall is raised in the issue cycle itself.
  - On issue, capture opa, opb, func and rm_res into dp_* and load cnt <= LAT(class)-1.
  - Next state is DONE if LAT(class)==1, otherwise BUSY.
- BUSY:
  - fpu_busy=1; cnt decrements every cycle.
  - When cnt==1 (or cnt==0), next state is DONE. BUSY therefore lasts exactly LAT-1 cycles.
- DONE:
  - fpu_busy=0, fpu_res_valid=1, fpu_res=dp_res.
  - Next state is IDLE unconditionally. The pipeline advances at the end of DONE, so the instruction still present in ID/EX during DONE is never re-issued.
- Timing: an op issued in cycle T has fpu_res_valid in cycle T+LAT. The earliest next issue is T+LAT+1.
- Rounding mode:
  - rm_res = (flt_rm==3'b111) ? frm_csr : flt_rm.
  - If rm_res is 5, 6 or 7, the op still sequences with its normal latency. The controller registers the flag, and fpu_illegal_rm=1 only during DONE.
- dp_* hold their captured values from the issue edge until the next issue; they do not change in BUSY or DONE.
- Flush has priority over everything else:
  - In IDLE, ex_flush suppresses issue, so fpu_busy=0.
  - In BUSY or DONE, ex_flush sends the next state to IDLE. If asserted during DONE, fpu_res_valid and fpu_res still show in that cycle, but the consumer must discard them.
  - In BUSY, fpu_busy stays 1 in the flush cycle, and fpu_res_valid is never generated for the squashed op.
- Back-to-back FP ops: the second op sits in ID/EX after DONE and issues in the following IDLE cycle. There is one idle bubble between ops.

Test Plan:
1. FCVTSW single-cycle op:
   - Stimulus: reset, then ex_valid=1, func=ALU_FCVTSW, opa=32'hFFFFFFFF, flt_rm=0.
   - Required: fpu_busy=1 at T; at T+1 fpu_res_valid=1, fpu_res=32'hBF800000, fpu_busy=0.
2. FDIV with default LAT_DIV=16:
   - Stimulus: FDIV issued at T.
   - Required: fpu_busy high T..T+15; fpu_res_valid exactly at T+16; dp_opa/dp_opb stable T+1..T+16.
3. Flush mid-operation:
   - Stimulus: FMUL issued at T; ex_flush=1 at T+2.
   - Required: state is IDLE at T+3; no fpu_res_valid through T+10; fpu_busy=0 from T+3.
4. Back-to-back ops and non-FP funcs:
   - Stimulus: FADD then FSUB with ex_valid held; a non-FP func in between.
   - Required: results at T+3 and T+7; the non-FP func never raises fpu_busy.
5. Rounding-mode resolution:
   - Stimulus A: flt_rm=3'b111, frm_csr=3'b010. Required: dp_rm=2, fpu_illegal_rm=0.
   - Stimulus B: flt_rm=3'b101. Required: fpu_illegal_rm=1 only in the DONE cycle.
6. Reset mid-operation:
   - Stimulus: assert rst=0 asynchronously (between clock edges) during FDIV BUSY.
   - Required: fpu_busy, fpu_res_valid and dp_* are 0 immediately. After release, a new FCVTSWU with opa=5 gives fpu_res=32'h40A00000 one cycle after issue.
